ext_out_port: RTL and testbench

EXT_OUT_PORT -- requirements
Module: ext_out_port

---
 rtl/ext_port_pkg.sv | 20 ++
 rtl/ext_out_port_if.sv | 54 +++++
 rtl/out_fifo_mem.sv | 33 +++
 rtl/ext_out_port.sv | 90 +++++++++
 tb/tb_ext_out_port.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ext_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_port_pkg
//  Description : Shared constants and types for the external I/O port blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package ext_port_pkg;

    localparam int c_DATA_WIDTH = 11;
    localparam int c_DEPTH      = 4;

    typedef logic [c_DATA_WIDTH-1:0] ext_word_t;

    // Occupancy counter width: one extra bit so that a full buffer is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : ext_port_pkg
`default_nettype wire

// File: rtl/ext_out_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : ext_out_port_if
//  Description : Store-path and external-consumer signals of the output port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ext_out_port_if
    import ext_port_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_DEPTH
);

    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   acc_in;
    logic                    ext_ready;
    logic                    ovf_clr;
    logic [DATA_WIDTH-1:0]   ext_out;
    logic                    ext_valid;
    logic                    out_full;
    logic                    out_empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;

    // Control unit and external consumer side
    modport master (
        output wr_en,
        output acc_in,
        output ext_ready,
        output ovf_clr,
        input  ext_out,
        input  ext_valid,
        input  out_full,
        input  out_empty,
        input  count,
        input  overflow
    );

    // Output port side
    modport slave (
        input  wr_en,
        input  acc_in,
        input  ext_ready,
        input  ovf_clr,
        output ext_out,
        output ext_valid,
        output out_full,
        output out_empty,
        output count,
        output overflow
    );

endinterface : ext_out_port_if
`default_nettype wire

// File: rtl/out_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : out_fifo_mem
//  Description : DEPTH x DATA_WIDTH register array, one write / one async read.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_fifo_mem
    import ext_port_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_DEPTH
) (
    input  wire logic                       clk,
    input  wire logic                       wr_en,
    input  wire logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  wire logic [DATA_WIDTH-1:0]      wr_data,
    input  wire logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic      [DATA_WIDTH-1:0]      rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Contents are left untouched by reset; the read side is only meaningful while valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : out_fifo_mem
`default_nettype wire

// File: rtl/ext_out_port.sv
`default_nettype none
// ============================================================================
//  Module      : ext_out_port
//  Description : FIFO from the processor store path to the external output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_out_port
    import ext_port_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_DEPTH
) (
    input  wire logic        clk,
    input  wire logic        reset,
    ext_out_port_if.slave    bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] c_FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_accept;
    logic                   w_wr_drop;
    logic                   w_xfer;
    logic [DATA_WIDTH-1:0]  w_rd_data;

    assign w_full      = (r_count == c_FULL_COUNT);
    assign w_empty     = (r_count == '0);
    // A full buffer drops the store even when the consumer drains this cycle.
    assign w_wr_accept = bus.wr_en & ~w_full;
    assign w_wr_drop   = bus.wr_en &  w_full;
    assign w_xfer      = bus.ext_ready & ~w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_wr_accept, w_xfer})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A drop in the same cycle as a clear wins so the event is not lost.
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    out_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_wr_accept),
        .wr_addr (r_wr_ptr),
        .wr_data (bus.acc_in),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    assign bus.ext_out   = w_rd_data;
    assign bus.ext_valid = ~w_empty;
    assign bus.out_full  = w_full;
    assign bus.out_empty = w_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;

endmodule : ext_out_port
`default_nettype wire

// File: tb/tb_ext_out_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_out_port
//  Description : Self-checking bench for ext_out_port (vectors + queue model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_out_port;

    localparam int DW    = 11;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    ext_out_port_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    ext_out_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic          rdy;
        logic          clr;
        int            cnt;
        logic          valid;
        logic [DW-1:0] dout;
        logic          ovf;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] mq[$];
    logic          m_ovf;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input int data, input logic rdy, input logic clr,
                                input int cnt, input int dout, input logic ovf);
        vec_t v;
        v.wr = wr; v.data = DW'(data); v.rdy = rdy; v.clr = clr;
        v.cnt = cnt; v.valid = (cnt != 0); v.dout = DW'(dout); v.ovf = ovf;
        return v;
    endfunction

    // One clock: drive at the falling edge, update the queue model at the rising edge.
    task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rdy, input logic clr);
        bit xfer, acc, drop;
        bus.wr_en = wr; bus.acc_in = d; bus.ext_ready = rdy; bus.ovf_clr = clr;
        xfer = (mq.size() > 0) && rdy;
        acc  = wr && (mq.size() < DEPTH);
        drop = wr && (mq.size() >= DEPTH);
        @(posedge clk);
        if (xfer) void'(mq.pop_front());
        if (acc)  mq.push_back(d);
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"},     32'(bus.count),     32'(mq.size()));
        chk({tag, ".ext_valid"}, 32'(bus.ext_valid), 32'(mq.size() != 0));
        chk({tag, ".out_empty"}, 32'(bus.out_empty), 32'(mq.size() == 0));
        chk({tag, ".out_full"},  32'(bus.out_full),  32'(mq.size() == DEPTH));
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
        if (mq.size() != 0) chk({tag, ".ext_out"}, 32'(bus.ext_out), 32'(mq[0]));
    endtask

    task automatic reset_dut();
        bus.wr_en = 0; bus.ext_ready = 0; bus.ovf_clr = 0; bus.acc_in = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] w [8];

        // Reset state, while held and after release
        reset = 1'b1;
        bus.wr_en = 0; bus.ext_ready = 0; bus.ovf_clr = 0; bus.acc_in = '0;
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check_model("reset_held");
        reset = 1'b0;
        cycle(0, '0, 1, 0);
        check_model("reset_idle");

        // Directed vectors: single word hold, fill/overflow/drain, empty underflow, overflow clear
        tbl.push_back(mk(1, 100,  0, 0, 1, 100,  0));
        tbl.push_back(mk(0, 0,    0, 0, 1, 100,  0));
        tbl.push_back(mk(0, 0,    0, 0, 1, 100,  0));
        tbl.push_back(mk(0, 0,    0, 0, 1, 100,  0));
        tbl.push_back(mk(0, 0,    1, 0, 0, 0,    0));
        tbl.push_back(mk(1, 1865, 0, 0, 1, 1865, 0));
        tbl.push_back(mk(1, 73,   0, 0, 2, 1865, 0));
        tbl.push_back(mk(1, 100,  0, 0, 3, 1865, 0));
        tbl.push_back(mk(1, 0,    0, 0, 4, 1865, 0));
        tbl.push_back(mk(1, 5,    0, 0, 4, 1865, 1));
        tbl.push_back(mk(0, 0,    1, 0, 3, 73,   1));
        tbl.push_back(mk(0, 0,    1, 0, 2, 100,  1));
        tbl.push_back(mk(0, 0,    1, 0, 1, 0,    1));
        tbl.push_back(mk(0, 0,    1, 0, 0, 0,    1));
        tbl.push_back(mk(0, 0,    1, 0, 0, 0,    1));
        tbl.push_back(mk(1, 1,    0, 0, 1, 1,    1));
        tbl.push_back(mk(1, 2,    0, 0, 2, 1,    1));
        tbl.push_back(mk(1, 3,    0, 0, 3, 1,    1));
        tbl.push_back(mk(1, 4,    0, 0, 4, 1,    1));
        tbl.push_back(mk(1, 9,    0, 1, 4, 1,    1));
        tbl.push_back(mk(0, 0,    0, 1, 4, 1,    0));
        tbl.push_back(mk(1, 7,    1, 0, 3, 2,    1));
        tbl.push_back(mk(0, 0,    0, 1, 3, 2,    0));
        tbl.push_back(mk(1, 50,   1, 0, 3, 3,    0));

        foreach (tbl[i]) begin
            cycle(tbl[i].wr, tbl[i].data, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d.count", i),     32'(bus.count),     32'(tbl[i].cnt));
            chk($sformatf("vec%0d.ext_valid", i), 32'(bus.ext_valid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d.out_full", i),  32'(bus.out_full),  32'(tbl[i].cnt == DEPTH));
            chk($sformatf("vec%0d.out_empty", i), 32'(bus.out_empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("vec%0d.overflow", i),  32'(bus.overflow),  32'(tbl[i].ovf));
            if (tbl[i].valid) chk($sformatf("vec%0d.ext_out", i), 32'(bus.ext_out), 32'(tbl[i].dout));
        end

        // Steady write+transfer at count=2 across pointer wrap
        reset_dut();
        for (int i = 0; i < 8; i++) w[i] = DW'($urandom);
        cycle(1, w[0], 0, 0);
        cycle(1, w[1], 0, 0);
        for (int k = 0; k < 6; k++) begin
            cycle(1, w[k+2], 1, 0);
            chk($sformatf("stream%0d.count", k),   32'(bus.count),   32'd2);
            chk($sformatf("stream%0d.ext_out", k), 32'(bus.ext_out), 32'(w[k+1]));
        end

        // Asynchronous reset between edges with three words buffered
        reset_dut();
        for (int i = 0; i < 3; i++) cycle(1, DW'(i + 20), 0, 0);
        chk("pre_async.count", 32'(bus.count), 32'd3);
        bus.wr_en = 0; bus.ext_ready = 1; bus.ovf_clr = 0;
        @(posedge clk);
        void'(mq.pop_front());
        #2;
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        chk("async.ext_valid", 32'(bus.ext_valid), 32'd0);
        chk("async.count",     32'(bus.count),     32'd0);
        chk("async.out_empty", 32'(bus.out_empty), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        check_model("after_async");

        // Randomised traffic against the queue model: fill-biased, then drain-biased
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            int pw, pr;
            pw = (i < 200) ? 70 : 35;
            pr = (i < 200) ? 35 : 70;
            cycle($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < pr,
                  $urandom_range(0, 99) < 8);
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_ext_out_port
`default_nettype wire
